// File: rtl/lcd_write_engine_if.sv
// Byte push channel into the LCD write engine: {rs, data} offered with write_en,
// ready is high while the engine's byte FIFO has room.
interface lcd_write_engine_if;
    logic [7:0] data;
    logic       rs;
    logic       write_en;
    logic       ready;

    modport master (output data, rs, write_en, input ready);
    modport slave  (input data, rs, write_en, output ready);
endinterface

// File: rtl/lcd_write_engine.sv
// HD44780 4-bit write engine: byte FIFO, two-nibble serialiser with programmable E timing.
// Define LCD_INIT_SEQ_EN to run the power-up init nibble sequence after every reset.
module lcd_write_engine #(
    parameter int FIFO_DEPTH   = 4,
    parameter int T_POWERUP    = 750000,
    parameter int T_SETUP      = 2,
    parameter int T_EN_HIGH    = 12,
    parameter int T_NIBBLE_GAP = 50,
    parameter int T_CMD_WAIT   = 2000,
    parameter int T_CLEAR_WAIT = 82000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    lcd_write_engine_if.slave wr_if,
    output logic              busy_o,
    output logic              init_done_o,
    output logic              overflow_o,
    output logic [3:0]        lcd_data_o,
    output logic              lcd_e_o,
    output logic              lcd_rs_o,
    output logic              lcd_rw_o,
    output logic              lcd_sf_ce_o
);

    function automatic int max2(int a, int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_POWERUP, T_SETUP), max2(T_EN_HIGH, T_NIBBLE_GAP)),
                                max2(T_CMD_WAIT, T_CLEAR_WAIT));
    localparam int TW = $clog2(T_MAX) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    // Timers are loaded with N-1 so a phase of N cycles ends when the count reaches zero.
    localparam logic [TW-1:0] LD_SETUP = TW'(T_SETUP - 1);
    localparam logic [TW-1:0] LD_EN    = TW'(T_EN_HIGH - 1);
    localparam logic [TW-1:0] LD_GAP   = TW'(T_NIBBLE_GAP - 1);
    localparam logic [TW-1:0] LD_CMD   = TW'(T_CMD_WAIT - 1);
    localparam logic [TW-1:0] LD_CLR   = TW'(T_CLEAR_WAIT - 1);

    typedef enum logic [2:0] {
`ifdef LCD_INIT_SEQ_EN
        S_POWERUP,
`endif
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

`ifdef LCD_INIT_SEQ_EN
    localparam state_t RST_STATE = S_POWERUP;
    // First POWERUP cycle arms the timer, so it is loaded with two less than the wait.
    localparam logic [TW-1:0] LD_PWR = TW'((T_POWERUP >= 2) ? T_POWERUP - 2 : 0);
`else
    localparam state_t RST_STATE = S_IDLE;
`endif

    logic [8:0]    fifo_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          full, empty, push, pop;
    logic [8:0]    head;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [8:0]    byte_q, byte_d;
    logic          lo_q, lo_d;
    logic          init_done_q, init_done_d;
    logic [3:0]    lcd_d_q, lcd_d_d;
    logic          lcd_rs_q, lcd_rs_d;
    logic          ovf_q;
    logic          tmr_done, long_wait;
`ifdef LCD_INIT_SEQ_EN
    logic [1:0]    init_idx_q, init_idx_d;
    logic          arm_q, arm_d;
`endif

    assign full  = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = wr_if.write_en && !full;
    assign head  = fifo_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= {wr_if.rs, wr_if.data};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW + 1)'(push) - (AW + 1)'(pop);
            // Full is judged before any same-cycle pop, so such a push is still dropped.
            if (wr_if.write_en && full) ovf_q <= 1'b1;
        end
    end

    assign tmr_done  = (timer_q == '0);
    assign long_wait = !byte_q[8] && (byte_q[7:2] == 6'd0) && (byte_q[1:0] != 2'd0);

    always_comb begin
        state_d     = state_q;
        timer_d     = tmr_done ? timer_q : timer_q - 1'b1;
        byte_d      = byte_q;
        lo_d        = lo_q;
        lcd_d_d     = lcd_d_q;
        lcd_rs_d    = lcd_rs_q;
        pop         = 1'b0;
`ifdef LCD_INIT_SEQ_EN
        init_done_d = init_done_q;
        init_idx_d  = init_idx_q;
        arm_d       = arm_q;
`else
        init_done_d = 1'b1;
`endif
        case (state_q)
`ifdef LCD_INIT_SEQ_EN
            S_POWERUP: begin
                arm_d = 1'b1;
                if (arm_q ? tmr_done : (T_POWERUP <= 1)) begin
                    state_d  = S_SETUP;
                    timer_d  = LD_SETUP;
                    lcd_d_d  = 4'h3;
                    lcd_rs_d = 1'b0;
                end else if (!arm_q) begin
                    timer_d = LD_PWR;
                end
            end
`endif
            S_IDLE: begin
                if (init_done_q && !empty) begin
                    pop      = 1'b1;
                    byte_d   = head;
                    lo_d     = 1'b0;
                    state_d  = S_SETUP;
                    timer_d  = LD_SETUP;
                    lcd_d_d  = head[7:4];
                    lcd_rs_d = head[8];
                end
            end
            S_SETUP: begin
                if (tmr_done) begin
                    state_d = S_PULSE;
                    timer_d = LD_EN;
                end
            end
            S_PULSE: begin
                if (tmr_done) begin
                    state_d = S_HOLD;
                    timer_d = LD_GAP;
                end
            end
            S_HOLD: begin
                if (tmr_done) begin
`ifdef LCD_INIT_SEQ_EN
                    if (!init_done_q) begin
                        state_d = S_WAIT;
                        timer_d = (init_idx_q == 2'd0) ? LD_CLR : LD_CMD;
                    end else
`endif
                    if (!lo_q) begin
                        lo_d    = 1'b1;
                        state_d = S_SETUP;
                        timer_d = LD_SETUP;
                        lcd_d_d = byte_q[3:0];
                    end else begin
                        state_d = S_WAIT;
                        timer_d = long_wait ? LD_CLR : LD_CMD;
                    end
                end
            end
            S_WAIT: begin
                if (tmr_done) begin
`ifdef LCD_INIT_SEQ_EN
                    if (!init_done_q) begin
                        if (init_idx_q == 2'd3) begin
                            state_d     = S_IDLE;
                            init_done_d = 1'b1;
                        end else begin
                            // Init nibbles run 0x3, 0x3, 0x3, then 0x2 to select 4-bit mode.
                            init_idx_d = init_idx_q + 2'd1;
                            state_d    = S_SETUP;
                            timer_d    = LD_SETUP;
                            lcd_d_d    = (init_idx_q == 2'd2) ? 4'h2 : 4'h3;
                        end
                    end else
`endif
                    state_d = S_IDLE;
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RST_STATE;
            timer_q     <= '0;
            lo_q        <= 1'b0;
            init_done_q <= 1'b0;
            lcd_d_q     <= 4'h0;
            lcd_rs_q    <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
            init_idx_q  <= 2'd0;
            arm_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            lo_q        <= lo_d;
            init_done_q <= init_done_d;
            lcd_d_q     <= lcd_d_d;
            lcd_rs_q    <= lcd_rs_d;
`ifdef LCD_INIT_SEQ_EN
            init_idx_q  <= init_idx_d;
            arm_q       <= arm_d;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        byte_q <= byte_d;
    end

    assign wr_if.ready = !full;
    assign busy_o      = (state_q != S_IDLE) || !empty || !init_done_q;
    assign init_done_o = init_done_q;
    assign overflow_o  = ovf_q;
    assign lcd_data_o  = lcd_d_q;
    assign lcd_e_o     = (state_q == S_PULSE);
    assign lcd_rs_o    = lcd_rs_q;
    assign lcd_rw_o    = 1'b0;
    assign lcd_sf_ce_o = 1'b1;

endmodule
